// File: rtl/gold_correlator_rx.sv
// -----------------------------------------------------------------------------
// gold_correlator_rx
//
// Receive-side Gold code correlator. The block regenerates the transmitter's
// Gold sequence from two 6-bit m-sequence LFSRs. The m2 phase is set by
// code2_i. Incoming chips are correlated against this local code over one
// code period. While searching, the local code is slipped one chip per failed
// period until |correlation| reaches THRESH. Once locked, the block despreads
// one data bit per period and drops lock after MISS_MAX consecutive weak
// periods.
//
// Ports:
//   clkin         system clock, rising edge
//   rstn          asynchronous active-low reset
//   start_i       one-cycle pulse: latch code2_i and (re)start acquisition
//   code2_i       m2 phase offset in chips, 0..N-1
//   chip_i        received chip (0/1)
//   chip_valid_i  chip_i qualifier
//   ready_o       high while chips are accepted (SEARCH or LOCK)
//   corr_o        signed correlation of the last completed period
//   corr_valid_o  one-cycle pulse when corr_o updates
//   lock_o        high in LOCK
//   phase_o       number of slips applied, mod N
//   bit_o         despread data bit (1 when correlation is negative)
//   bit_valid_o   one-cycle pulse with bit_o, LOCK periods only
// -----------------------------------------------------------------------------
module gold_correlator_rx #(
  parameter int                N        = 63,
  parameter int                LENGTH   = $clog2(N),
  parameter logic [LENGTH-1:0] POLY1    = 6'b000011,
  parameter logic [LENGTH-1:0] POLY2    = 6'b100111,
  parameter logic [6:0]        THRESH   = 7'd40,
  parameter int                MISS_MAX = 3
) (
  input  logic                clkin,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [LENGTH-1:0]   code2_i,
  input  logic                chip_i,
  input  logic                chip_valid_i,
  output logic                ready_o,
  output logic signed [6:0]   corr_o,
  output logic                corr_valid_o,
  output logic                lock_o,
  output logic [LENGTH-1:0]   phase_o,
  output logic                bit_o,
  output logic                bit_valid_o
);

  localparam int ACC_W  = 7;
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  localparam logic signed [ACC_W-1:0] ACC_P1 = 7'sd1;
  localparam logic signed [ACC_W-1:0] ACC_M1 = -7'sd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    SEARCH  = 2'd2,
    LOCK    = 2'd3
  } state_t;

  // Fibonacci step: output is s[0], feedback enters at the top bit.
  function automatic logic [LENGTH-1:0] f_lfsr_step(input logic [LENGTH-1:0] s,
                                                    input logic [LENGTH-1:0] poly);
    return {^(s & poly), s[LENGTH-1:1]};
  endfunction

  // |acc| fits in ACC_W-1 bits because |acc| <= N, so negation never overflows.
  function automatic logic [ACC_W-1:0] f_abs(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  function automatic logic [LENGTH-1:0] f_phase_inc(input logic [LENGTH-1:0] p);
    return (p == LENGTH'(N - 1)) ? '0 : p + LENGTH'(1);
  endfunction

  state_t                   r_state;
  logic [LENGTH-1:0]        r_lfsr1;
  logic [LENGTH-1:0]        r_lfsr2;
  logic [LENGTH-1:0]        r_cnt;
  logic [LENGTH-1:0]        r_chip_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_slip;
  logic [MISS_W-1:0]        r_miss;
  logic [LENGTH-1:0]        r_phase;
  logic signed [ACC_W-1:0]  r_corr;
  logic                     r_corr_valid;
  logic                     r_lock;
  logic                     r_bit;
  logic                     r_bit_valid;

  logic                     w_local;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic                     w_last;
  logic                     w_hit;

  assign w_local   = r_lfsr1[0] ^ r_lfsr2[0];
  assign w_acc_nxt = r_acc + ((chip_i == w_local) ? ACC_P1 : ACC_M1);
  assign w_last    = (r_chip_cnt == LENGTH'(N - 1));
  assign w_hit     = (f_abs(w_acc_nxt) >= THRESH);

  // Reset is asserted asynchronously; release is assumed synchronised upstream.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_lfsr1      <= '1;
      r_lfsr2      <= '1;
      r_cnt        <= '0;
      r_chip_cnt   <= '0;
      r_acc        <= '0;
      r_slip       <= 1'b0;
      r_miss       <= '0;
      r_phase      <= '0;
      r_corr       <= '0;
      r_corr_valid <= 1'b0;
      r_lock       <= 1'b0;
      r_bit        <= 1'b0;
      r_bit_valid  <= 1'b0;
    end else begin
      r_corr_valid <= 1'b0;
      r_bit_valid  <= 1'b0;
      if (start_i) begin
        // Restart has priority over everything, including a period end.
        // corr_o is deliberately left holding its last value.
        r_lfsr1    <= '1;
        r_lfsr2    <= '1;
        r_cnt      <= code2_i;
        r_chip_cnt <= '0;
        r_acc      <= '0;
        r_slip     <= 1'b0;
        r_miss     <= '0;
        r_phase    <= '0;
        r_lock     <= 1'b0;
        r_state    <= (code2_i == '0) ? SEARCH : PRELOAD;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          PRELOAD: begin
            // One m2 step per clock; code2_i steps in total.
            r_lfsr2 <= f_lfsr_step(r_lfsr2, POLY2);
            r_cnt   <= r_cnt - LENGTH'(1);
            if (r_cnt <= LENGTH'(1)) r_state <= SEARCH;
          end
          SEARCH, LOCK: begin
            if (chip_valid_i) begin
              if (r_slip) begin
                // Discarding one received chip retards the local code by one chip.
                r_slip <= 1'b0;
              end else begin
                r_lfsr1 <= f_lfsr_step(r_lfsr1, POLY1);
                r_lfsr2 <= f_lfsr_step(r_lfsr2, POLY2);
                if (w_last) begin
                  r_acc        <= '0;
                  r_chip_cnt   <= '0;
                  r_corr       <= w_acc_nxt;
                  r_corr_valid <= 1'b1;
                  if (r_state == SEARCH) begin
                    if (w_hit) begin
                      r_state <= LOCK;
                      r_lock  <= 1'b1;
                      r_miss  <= '0;
                    end else begin
                      r_slip  <= 1'b1;
                      r_phase <= f_phase_inc(r_phase);
                    end
                  end else begin
                    // A bit is emitted every locked period, even the one dropping lock.
                    r_bit_valid <= 1'b1;
                    r_bit       <= w_acc_nxt[ACC_W-1];
                    if (w_hit) begin
                      r_miss <= '0;
                    end else if (r_miss == MISS_W'(MISS_MAX - 1)) begin
                      r_state <= SEARCH;
                      r_lock  <= 1'b0;
                      r_slip  <= 1'b1;
                      r_phase <= f_phase_inc(r_phase);
                      r_miss  <= '0;
                    end else begin
                      r_miss <= r_miss + MISS_W'(1);
                    end
                  end
                end else begin
                  r_acc      <= w_acc_nxt;
                  r_chip_cnt <= r_chip_cnt + LENGTH'(1);
                end
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign ready_o      = (r_state == SEARCH) || (r_state == LOCK);
  assign corr_o       = r_corr;
  assign corr_valid_o = r_corr_valid;
  assign lock_o       = r_lock;
  assign phase_o      = r_phase;
  assign bit_o        = r_bit;
  assign bit_valid_o  = r_bit_valid;

endmodule

// File: tb/tb_gold_correlator_rx.sv
// -----------------------------------------------------------------------------
// tb_gold_correlator_rx
//
// Directed bench for gold_correlator_rx. A local transmitter model produces the
// Gold code chips. Expected correlator results are the fixed values the
// receiver must produce: +63/-63 when aligned, slip count on acquisition,
// the miss sequence on lock loss, and zeroed outputs on restart or reset.
// -----------------------------------------------------------------------------
module tb_gold_correlator_rx;

  localparam logic [5:0] P1 = 6'b000011;
  localparam logic [5:0] P2 = 6'b100111;

  logic              clkin = 1'b0;
  logic              rstn;
  logic              start_i;
  logic [5:0]        code2_i;
  logic              chip_i;
  logic              chip_valid_i;
  logic              ready_o;
  logic signed [6:0] corr_o;
  logic              corr_valid_o;
  logic              lock_o;
  logic [5:0]        phase_o;
  logic              bit_o;
  logic              bit_valid_o;

  gold_correlator_rx dut (
    .clkin        (clkin),
    .rstn         (rstn),
    .start_i      (start_i),
    .code2_i      (code2_i),
    .chip_i       (chip_i),
    .chip_valid_i (chip_valid_i),
    .ready_o      (ready_o),
    .corr_o       (corr_o),
    .corr_valid_o (corr_valid_o),
    .lock_o       (lock_o),
    .phase_o      (phase_o),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid_o)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  // Transmitter state and per-period capture of the corr_valid_o cycle.
  logic [5:0] t1, t2;
  int n_cv, n_bv, n_tick, s_cv_tick;
  int s_corr, s_bit, s_bv, s_lock, s_phase;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] p);
    return {^(s & p), s[5:1]};
  endfunction

  task automatic tx_adv();
    t1 = lfsr_step(t1, P1);
    t2 = lfsr_step(t2, P2);
  endtask

  // Transmitter at phase 'adv' of the Gold code selected by code2.
  task automatic tx_reset(input int code2, input int adv);
    t1 = '1;
    t2 = '1;
    for (int i = 0; i < code2; i++) t2 = lfsr_step(t2, P2);
    for (int i = 0; i < adv; i++) tx_adv();
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    n_tick++;
    if (corr_valid_o) begin
      n_cv++;
      s_cv_tick = n_tick;
      s_corr    = corr_o;
      s_bit     = bit_o;
      s_bv      = bit_valid_o;
      s_lock    = lock_o;
      s_phase   = phase_o;
    end
    if (bit_valid_o) n_bv++;
  endtask

  task automatic send_chip(input logic c);
    chip_i       = c;
    chip_valid_i = 1'b1;
    tick();
    chip_valid_i = 1'b0;
  endtask

  task automatic send_period(input logic inv, input logic zero, input logic gap);
    n_cv   = 0;
    n_bv   = 0;
    n_tick = 0;
    for (int i = 0; i < 63; i++) begin
      send_chip(zero ? 1'b0 : ((t1[0] ^ t2[0]) ^ inv));
      tx_adv();
      if (gap) tick();
    end
  endtask

  // Pulse start_i and count clocks until ready_o, bounded.
  task automatic do_start(input logic [5:0] code2, output int waited);
    start_i = 1'b1;
    code2_i = code2;
    tick();
    start_i = 1'b0;
    waited  = 0;
    while (!ready_o && waited < 100) begin
      tick();
      waited++;
    end
  endtask

  int waited, tot_bv, misses, locked;

  initial begin
    rstn = 1'b0; start_i = 1'b0; code2_i = '0; chip_i = 1'b0; chip_valid_i = 1'b0;
    n_tick = 0;
    repeat (3) tick();
    check("rst_ready", ready_o, 0);
    check("rst_corr", corr_o, 0);
    check("rst_lock", lock_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_cvalid", corr_valid_o, 0);
    check("rst_bvalid", bit_valid_o, 0);
    rstn = 1'b1;
    tick();

    // Aligned acquisition with code2 = 5.
    do_start(6'd5, waited);
    check("preload_cycles", waited, 5);
    tx_reset(5, 0);
    send_period(1'b0, 1'b0, 1'b0);
    check("aln_cv_count", n_cv, 1);
    check("aln_latency", s_cv_tick, 63);
    check("aln_corr", s_corr, 63);
    check("aln_lock", s_lock, 1);
    check("aln_phase", s_phase, 0);
    check("aln_no_bit", n_bv, 0);

    // Inverted period, then a normal one.
    send_period(1'b1, 1'b0, 1'b0);
    check("inv_corr", s_corr, -63);
    check("inv_bvalid", s_bv, 1);
    check("inv_bit", s_bit, 1);
    send_period(1'b0, 1'b0, 1'b0);
    check("nrm_corr", s_corr, 63);
    check("nrm_bit", s_bit, 0);
    check("nrm_bvalid", s_bv, 1);

    // Loss of lock: three all-zero periods.
    tot_bv = 0;
    send_period(1'b0, 1'b1, 1'b0);
    tot_bv += n_bv;
    check("loss1_lock", s_lock, 1);
    send_period(1'b0, 1'b1, 1'b0);
    tot_bv += n_bv;
    check("loss2_lock", s_lock, 1);
    send_period(1'b0, 1'b1, 1'b0);
    tot_bv += n_bv;
    check("loss3_lock", s_lock, 0);
    check("loss3_phase", s_phase, 1);
    check("loss_bits", tot_bv, 3);
    check("loss_ready", ready_o, 1);

    // Offset acquisition: transmitted code is 10 chips late.
    do_start(6'd5, waited);
    check("restart_phase", phase_o, 0);
    tx_reset(5, 53);
    misses = 0;
    locked = 0;
    for (int i = 0; i < 1200 && locked == 0; i++) begin
      send_chip(t1[0] ^ t2[0]);
      tx_adv();
      if (corr_valid_o) begin
        if (lock_o) locked = 1;
        else misses++;
      end
    end
    check("ofs_locked", locked, 1);
    check("ofs_misses", misses, 10);
    check("ofs_phase", phase_o, 10);
    check("ofs_corr", corr_o, 63);

    // Restart coinciding with the last chip of a locked period.
    n_cv = 0;
    for (int i = 0; i < 62; i++) begin
      send_chip(t1[0] ^ t2[0]);
      tx_adv();
    end
    check("mid_no_cv", n_cv, 0);
    chip_i       = t1[0] ^ t2[0];
    chip_valid_i = 1'b1;
    start_i      = 1'b1;
    code2_i      = 6'd0;
    tick();
    start_i      = 1'b0;
    chip_valid_i = 1'b0;
    check("rs_cvalid", corr_valid_o, 0);
    check("rs_lock", lock_o, 0);
    check("rs_phase", phase_o, 0);
    check("rs_ready", ready_o, 1);
    check("rs_corr_hold", corr_o, 63);

    // Gapped aligned period with code2 = 0.
    tx_reset(0, 0);
    send_period(1'b0, 1'b0, 1'b1);
    check("gap_cv_count", n_cv, 1);
    check("gap_latency", s_cv_tick, 125);
    check("gap_corr", s_corr, 63);
    check("gap_lock", s_lock, 1);
    check("gap_phase", s_phase, 0);

    // Asynchronous reset in the middle of a locked period.
    for (int i = 0; i < 30; i++) begin
      send_chip(t1[0] ^ t2[0]);
      tx_adv();
    end
    check("pre_rst_lock", lock_o, 1);
    rstn = 1'b0;
    #1;
    check("arst_lock", lock_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_corr", corr_o, 0);
    check("arst_bit", bit_o, 0);
    check("arst_cvalid", corr_valid_o, 0);
    #20;
    rstn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
